shot_scheduler: RTL
===================

Name: shot_scheduler

Overview:
- Owns the pool of player shots.
- On each movement tick it sequences through every slot: advances live shots upward, retires shots that leave the top of the screen, then spawns a new shot at the player position if shoot is held and the cooldown allows.
- Sits between decoder_sig/reimu and vga_RGB. vga_RGB reads slot state through a registered read port.

Parameters:
- NSHOT, 8, number of shot slots (power of two, 2..16).
- SPEED, 4, pixels subtracted from y per tick.
- COOLDOWN, 6, ticks between successive spawns.
- IDXW, 3, log2(NSHOT).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tick  in  1  one-cycle movement strobe (one per frame step)
- shoot  in  1  level, fire held
- gameover  in  1  level, clears pool and inhibits spawn
- reimux  in  10  player x (0..639)
- reimuy  in  10  player y (0..479)
- rd_idx  in  IDXW  slot index requested by renderer
- rd_valid  out  1  slot live (registered)
- rd_x  out  10  slot x (registered)
- rd_y  out  10  slot y (registered)
- active_cnt  out  IDXW+1  number of live slots
- busy  out  1  update sequence in progress
- spawned  out  1  one-cycle pulse, shot allocated
- pool_full  out  1  one-cycle pulse, spawn refused because no free slot
- tick_miss  out  1  one-cycle pulse, tick dropped

Behaviour:
- Reset (async):
  - All slot valid bits, x, y = 0.
  - cooldown = 0; FSM in IDLE; pending = 0.
  - All outputs = 0.
- FSM states: IDLE, UPDATE, SPAWN.
- IDLE: on tick (or pending set), go to UPDATE with slot pointer = 0 and clear pending.
- UPDATE: one slot per cycle, pointer 0..NSHOT-1.
  - If gameover: valid <= 0.
  - Else if valid and y < SPEED: valid <= 0 (retire; no 10-bit wrap).
  - Else if valid: y <= y - SPEED.
  - After slot NSHOT-1, go to SPAWN.
- SPAWN: one cycle, then IDLE.
  - If cooldown != 0: cooldown decrements, no spawn.
  - Else if shoot && !gameover && reimuy >= SPEED:
    - Lowest-index free slot gets valid = 1, x = reimux, y = reimuy.
    - cooldown <= COOLDOWN; spawned pulses.
    - If no free slot: pool_full pulses and cooldown stays 0, so a retry occurs on the next tick.
- Latency: tick at cycle T gives busy = 1 for cycles T+1..T+NSHOT+1 and spawned/pool_full in cycle T+NSHOT+1. Minimum tick-to-tick spacing without pending is NSHOT+2 cycles.
- Tick while busy:
  - If pending = 0, set pending; the next UPDATE starts the cycle after SPAWN.
  - If pending = 1, drop the tick and pulse tick_miss.
- Read port:
  - rd_valid/rd_x/rd_y sample slot[rd_idx] with 1-cycle latency.
  - If a slot is written in the same cycle it is read, the old value is returned.
- active_cnt:
  - Registered.
  - Reflects the live-slot count one cycle after any valid-bit change.
  - Equals popcount of valid at IDLE.
- gameover held: pool empties on the first tick and stays empty. cooldown still decrements.
- Reset mid-UPDATE: immediate return to reset state; no partial slot state survives.
- shoot and gameover simultaneous: gameover wins.

Test Plan:
- Reset then read all rd_idx -> rd_valid=0, rd_x=rd_y=0, active_cnt=0, busy=0.
- shoot=1, reimux=320, reimuy=400, one tick -> spawned at T+9, slot0 x=320 y=400, active_cnt=1. Next tick (shoot=0) -> slot0 y=396.
- Slot with y=6, SPEED=4, two ticks -> y=2, then retired; rd_valid=0, active_cnt decrements.
- shoot held for 60 ticks with reimuy=479 -> spawns only on ticks 1, 8, 15, ... (cooldown 6). Fill all 8 slots, then pool_full pulses and cooldown stays 0.
- Tick pulses at T, T+2, T+4 -> second tick pending and executes after first SPAWN; third pulses tick_miss.
- gameover=1 with 5 live slots, one tick -> all valid=0, active_cnt=0, no spawn though shoot=1. Assert rst at T+3 of an UPDATE -> all state zero immediately.

Source files
------------

// File: rtl/shot_scheduler_if.sv
// Renderer-facing read port of the shot pool: the renderer drives a slot
// index and gets that slot's registered state back one cycle later.
interface shot_scheduler_if #(
    parameter int IDXW = 3
);
    logic [IDXW-1:0] rd_idx;
    logic            rd_valid;
    logic [9:0]      rd_x;
    logic [9:0]      rd_y;

    modport master (output rd_idx, input rd_valid, rd_x, rd_y);
    modport slave  (input rd_idx, output rd_valid, rd_x, rd_y);
endinterface

// File: rtl/shot_scheduler.sv
// Player shot pool: on each movement tick, walks every slot to move or retire
// live shots, then optionally spawns one new shot at the player position.
module shot_scheduler #(
    parameter int NSHOT    = 8,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 6,
    parameter int IDXW     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             shoot,
    input  logic             gameover,
    input  logic [9:0]       reimux,
    input  logic [9:0]       reimuy,
    shot_scheduler_if.slave  rd,
    output logic [IDXW:0]    active_cnt,
    output logic             busy,
    output logic             spawned,
    output logic             pool_full,
    output logic             tick_miss
);
    localparam int         CDW     = $clog2(COOLDOWN + 1);
    localparam logic [9:0] SPEED_V = 10'(SPEED);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SPAWN
    } state_t;

    state_t             state, state_nx;
    logic [IDXW-1:0]    ptr;
    logic               pending;
    logic [CDW-1:0]     cooldown;

    logic               slot_valid [NSHOT];
    logic [9:0]         slot_x     [NSHOT];
    logic [9:0]         slot_y     [NSHOT];

    logic               free_found;
    logic [IDXW-1:0]    free_idx;
    logic               spawn_req;
    logic [IDXW:0]      live_cnt;

    // Free-slot search runs downward so the lowest free index is the one kept.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        live_cnt   = '0;
        for (int i = NSHOT - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
            live_cnt = live_cnt + {{IDXW{1'b0}}, slot_valid[i]};
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        spawn_req = (state == SPAWN) && (cooldown == '0) && shoot && !gameover
                    && (reimuy >= SPEED_V);
        spawned   = spawn_req && free_found;
        pool_full = spawn_req && !free_found;
        tick_miss = tick && busy && pending;
        case (state)
            IDLE:    if (tick || pending) state_nx = UPDATE;
            UPDATE:  if (ptr == IDXW'(NSHOT - 1)) state_nx = SPAWN;
            SPAWN:   state_nx = (tick || pending) ? UPDATE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A tick arriving during SPAWN chains straight into the next UPDATE, so it
    // never needs to be parked in pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            pending  <= 1'b0;
            cooldown <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    ptr     <= '0;
                    pending <= 1'b0;
                end
                UPDATE: begin
                    ptr <= ptr + IDXW'(1);
                    if (tick && !pending) pending <= 1'b1;
                end
                SPAWN: begin
                    ptr     <= '0;
                    pending <= 1'b0;
                    if (cooldown != '0) cooldown <= cooldown - CDW'(1);
                    else if (spawned)   cooldown <= CDW'(COOLDOWN);
                end
                default: ptr <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSHOT; i++) begin
                slot_valid[i] <= 1'b0;
                slot_x[i]     <= '0;
                slot_y[i]     <= '0;
            end
        end else begin
            if (state == UPDATE) begin
                if (gameover)
                    slot_valid[ptr] <= 1'b0;
                else if (slot_valid[ptr] && slot_y[ptr] < SPEED_V)
                    slot_valid[ptr] <= 1'b0;
                else if (slot_valid[ptr])
                    slot_y[ptr] <= slot_y[ptr] - SPEED_V;
            end
            if (spawned) begin
                slot_valid[free_idx] <= 1'b1;
                slot_x[free_idx]     <= reimux;
                slot_y[free_idx]     <= reimuy;
            end
        end
    end

    // Read port and live count sample the pre-edge slot state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_x     <= '0;
            rd.rd_y     <= '0;
            active_cnt  <= '0;
        end else begin
            rd.rd_valid <= slot_valid[rd.rd_idx];
            rd.rd_x     <= slot_x[rd.rd_idx];
            rd.rd_y     <= slot_y[rd.rd_idx];
            active_cnt  <= live_cnt;
        end
    end
endmodule
